seg7_mux_display: RTL and testbench

//  Parametrised N-digit multiplexed 7-segment score display. Accepts a binary value on a load

---
 rtl/seg7_pkg.sv | 33 +++
 rtl/bin2bcd_seq.sv | 77 +++++++
 rtl/seg7_mux_display.sv | 82 ++++++++
 tb/tb_seg7_mux_display.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns, converter FSM states and the digit decoder for the score display.
// Segment order is {top,top_right,bot_right,bot,bot_left,top_left,middle}, 1 = lit.
package seg7_pkg;
    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;
    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0: return SEG_0;
            4'd1: return SEG_1;
            4'd2: return SEG_2;
            4'd3: return SEG_3;
            4'd4: return SEG_4;
            4'd5: return SEG_5;
            4'd6: return SEG_6;
            4'd7: return SEG_7;
            4'd8: return SEG_8;
            4'd9: return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one input bit per cycle, MSB first.
// done_o is high for the single COMMIT cycle, when bcd_o holds the finished result.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int W = 10,
    parameter int D = 3
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           load_i,
    input  logic [W-1:0]   value_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [4*D-1:0] bcd_o
);
    localparam int CW = $clog2(W) + 1;

    state_t         state_q, state_d;
    logic [W-1:0]   sh_q, sh_d;
    logic [4*D-1:0] bcd_q, bcd_d, adj;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           last;

    assign last  = cnt_q == CW'(W - 1);
    assign bcd_o = bcd_q;

    always_ff @(posedge clock) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = load_i ? CONVERT : IDLE;
            CONVERT: state_d = last ? COMMIT : CONVERT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = state_q != IDLE;
        done_o = state_q == COMMIT;
    end

    // Nibbles of 5 or more get +3 before the shift so they carry correctly into the next decade.
    always_comb begin
        adj = bcd_q;
        for (int k = 0; k < D; k++)
            adj[4*k +: 4] = bcd_q[4*k +: 4] >= 4'd5 ? bcd_q[4*k +: 4] + 4'd3 : bcd_q[4*k +: 4];
        sh_d  = sh_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        if (state_q == IDLE && load_i) begin
            sh_d  = value_i;
            bcd_d = '0;
            cnt_d = '0;
        end else if (state_q == CONVERT) begin
            sh_d  = sh_q << 1;
            bcd_d = {adj[4*D-2:0], sh_q[W-1]};
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            sh_q  <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/seg7_mux_display.sv
// seg7_mux_display: N-digit multiplexed 7-segment score display with BCD conversion,
// leading-zero blanking and an overflow dash pattern.
module seg7_mux_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS         = 3,
    parameter int VALUE_WIDTH        = 10,
    parameter int REFRESH_DIV        = 1024,
    parameter int CATHODE_ACTIVE_LOW = 1,
    parameter int BLANK_LEADING      = 1
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   load,
    input  logic [VALUE_WIDTH-1:0] value,
    output logic                   busy,
    output logic                   overflow,
    output logic [NUM_DIGITS-1:0]  cathodes,
    output logic [6:0]             segments
);
    localparam int CW = $clog2(REFRESH_DIV) + 1;
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [31:0] LIMIT = 32'(10 ** NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] CATH_OFF = {NUM_DIGITS{CATHODE_ACTIVE_LOW != 0}};

    logic                    conv_done, tc, blank;
    logic [4*NUM_DIGITS-1:0] conv_bcd, dig_q, dig_d;
    logic                    ovf_pend_q, ovf_pend_d, ovf_q, ovf_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [NUM_DIGITS-1:0]   cath_q, cath_d;
    logic [6:0]              seg_q, seg_d;
    logic [3:0]              digit;

    bin2bcd_seq #(.W(VALUE_WIDTH), .D(NUM_DIGITS)) u_conv (
        .clock   (clock),
        .resetn  (resetn),
        .load_i  (load),
        .value_i (value),
        .busy_o  (busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    // Output stage decodes the next committed value so a commit shows the cycle after COMMIT.
    always_comb begin
        tc         = cnt_q == CW'(REFRESH_DIV - 1);
        cnt_d      = tc ? '0 : cnt_q + CW'(1);
        idx_d      = !tc ? idx_q : idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + IW'(1);
        ovf_pend_d = load && !busy ? 32'(value) >= LIMIT : ovf_pend_q;
        ovf_d      = conv_done ? ovf_pend_q : ovf_q;
        dig_d      = conv_done ? conv_bcd : dig_q;
        digit      = dig_d[{idx_q, 2'b00} +: 4];
        blank      = BLANK_LEADING != 0 && idx_q != '0 && (dig_d >> {idx_q, 2'b00}) == '0;
        seg_d      = ovf_d ? SEG_DASH : blank ? SEG_BLANK : seg_decode(digit);
        cath_d     = CATH_OFF ^ (NUM_DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            dig_q      <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            cath_q     <= CATH_OFF;
            seg_q      <= SEG_BLANK;
        end else begin
            ovf_pend_q <= ovf_pend_d;
            ovf_q      <= ovf_d;
            dig_q      <= dig_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            cath_q     <= cath_d;
            seg_q      <= seg_d;
        end
    end

    assign overflow = ovf_q;
    assign cathodes = cath_q;
    assign segments = seg_q;
endmodule

// File: tb/tb_seg7_mux_display.sv
// tb_seg7_mux_display: scoreboard bench for two display configurations sharing one stimulus stream.
// Expected display is derived arithmetically from the committed value and the refresh position.
module tb_seg7_mux_display;
    localparam int W  = 10;
    localparam int NA = 3;
    localparam int DA = 4;
    localparam int NB = 5;
    localparam int DB = 3;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          load = 1'b0;
    logic [W-1:0]  value = '0;
    logic          busy_a, ovf_a, busy_b, ovf_b;
    logic [NA-1:0] cath_a;
    logic [NB-1:0] cath_b;
    logic [6:0]    seg_a, seg_b;

    int          checks = 0;
    int          passes = 0;
    int unsigned exp_q[$];
    int unsigned k = 0;
    int unsigned bcnt = 0;
    int unsigned disp_v = 0;
    int          ia, ib;
    bit          armed = 0;
    bit          busy_prev = 0;
    logic [6:0]  pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                              7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    always #5 clk = ~clk;

    seg7_mux_display #(.NUM_DIGITS(NA), .VALUE_WIDTH(W), .REFRESH_DIV(DA),
                       .CATHODE_ACTIVE_LOW(1), .BLANK_LEADING(1)) dut_a (
        .clock(clk), .resetn(resetn), .load(load), .value(value),
        .busy(busy_a), .overflow(ovf_a), .cathodes(cath_a), .segments(seg_a)
    );

    seg7_mux_display #(.NUM_DIGITS(NB), .VALUE_WIDTH(W), .REFRESH_DIV(DB),
                       .CATHODE_ACTIVE_LOW(0), .BLANK_LEADING(0)) dut_b (
        .clock(clk), .resetn(resetn), .load(load), .value(value),
        .busy(busy_b), .overflow(ovf_b), .cathodes(cath_b), .segments(seg_b)
    );

    function automatic int unsigned pow10(int n);
        int unsigned p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] exp_seg(int unsigned v, int n, int idx, bit bl);
        int unsigned p = pow10(idx);
        if (v >= pow10(n)) return 7'b0000001;
        if (bl && idx > 0 && v < p) return 7'b0000000;
        return pat[(v / p) % 10];
    endfunction

    function automatic logic [7:0] exp_cath(int n, bit al, int idx, bit on);
        logic [7:0] mask = 8'((1 << n) - 1);
        logic [7:0] oh = on ? 8'(1 << idx) : 8'd0;
        return al ? (~oh & mask) : oh;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    // Input-side model: accepted loads go into the scoreboard, busy is a countdown.
    initial forever begin
        @(posedge clk);
        armed = 1'b1;
        if (!resetn) begin
            k = 0;
            bcnt = 0;
            exp_q.delete();
        end else begin
            k = k + 1;
            if (bcnt != 0) bcnt = bcnt - 1;
            else if (load) begin
                exp_q.push_back(32'(value));
                bcnt = W + 1;
            end
        end
    end

    // Output monitor: a falling busy pops the next committed value; display checked every cycle.
    initial forever begin
        @(negedge clk);
        if (armed) begin
            if (k == 0) begin
                disp_v = 0;
                busy_prev = 0;
            end else if (busy_prev && !busy_a) begin
                chk("commit_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    disp_v = exp_q.pop_front();
                    chk("commit_ovf_a", ovf_a, disp_v >= pow10(NA));
                end
            end
            chk("busy_a", busy_a, bcnt != 0);
            chk("busy_b", busy_b, bcnt != 0);
            chk("ovf_a", ovf_a, disp_v >= pow10(NA));
            chk("ovf_b", ovf_b, disp_v >= pow10(NB));
            ia = k == 0 ? 0 : int'(((k - 1) / DA) % NA);
            ib = k == 0 ? 0 : int'(((k - 1) / DB) % NB);
            chk("cath_a", cath_a, exp_cath(NA, 1, ia, k != 0));
            chk("seg_a", seg_a, k == 0 ? 7'b0 : exp_seg(disp_v, NA, ia, 1));
            chk("cath_b", cath_b, exp_cath(NB, 0, ib, k != 0));
            chk("seg_b", seg_b, k == 0 ? 7'b0 : exp_seg(disp_v, NB, ib, 0));
            busy_prev = busy_a;
        end
    end

    task automatic tick(bit ld, int unsigned v);
        load = ld;
        value = W'(v);
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) tick(0, 0);
    endtask

    initial begin
        int unsigned r, v;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        idle(30);
        tick(1, 507);  idle(45);
        tick(1, 42);   idle(45);
        tick(1, 1000); idle(45);
        tick(1, 999);  idle(45);
        tick(1, 123);  tick(0, 0); tick(1, 456); idle(45);
        tick(1, 888);  idle(5);
        resetn = 1'b0; tick(1, 300); resetn = 1'b1;
        idle(40);
        repeat (3000) begin
            r = $urandom_range(0, 9);
            v = r == 0 ? 999 : r == 1 ? 1000 : r == 2 ? 1023 : r == 3 ? $urandom_range(0, 99) : $urandom_range(0, 1023);
            if ($urandom_range(0, 599) == 0) begin
                resetn = 1'b0;
                tick(0, 0);
                resetn = 1'b1;
            end else tick($urandom_range(0, 3) == 0, v);
        end
        idle(40);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
